// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with operand bypass, EX/MEM register and iterative MDU with HI/LO (define MDU_FAST_MUL_EN for single-cycle multiply)
module ex_stage_md #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int FWD_SRCS = 2,
  parameter int SEL_W    = $clog2(FWD_SRCS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       isFlush,
  input  logic                       isCacheStall,
  input  logic [2:0]                 md_op,
  input  logic [DATA_W-1:0]          reg1_data,
  input  logic [DATA_W-1:0]          reg2_data,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_data,
  input  logic [SEL_W-1:0]           fwd_a,
  input  logic [SEL_W-1:0]           fwd_b,
  input  logic [DATA_W-1:0]          alu_out,
  output logic [DATA_W-1:0]          opa,
  output logic [DATA_W-1:0]          opb,
  input  logic [RADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]          reg_result,
  output logic [RADDR_W-1:0]         reg_write_reg,
  output logic                       reg_valid,
  output logic                       md_busy,
  output logic [DATA_W-1:0]          hi,
  output logic [DATA_W-1:0]          lo
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2;
  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_a, r_b, r_hi, r_lo;
  logic                r_div, r_neg_q, r_neg_r, r_dz;
  logic                w_stall, w_issue, w_load, w_sgn, w_is_div, w_dz, w_ge;
  logic [DATA_W-1:0]   w_ma, w_mb, w_diff, w_q, w_r, w_fix_hi, w_fix_lo;
  logic [DATA_W:0]     w_sum, w_cand;
  logic [2*DATA_W-1:0] w_mul_next, w_div_next, w_prod;
  // bypass muxes: select 0 or out-of-range picks register-file data
  always_comb begin
    opa = reg1_data;
    opb = reg2_data;
    for (int i = 1; i <= FWD_SRCS; i++) begin
      if (fwd_a == SEL_W'(i)) opa = fwd_data[(i-1)*DATA_W +: DATA_W];
      if (fwd_b == SEL_W'(i)) opb = fwd_data[(i-1)*DATA_W +: DATA_W];
    end
  end
  assign md_busy  = r_state != S_IDLE;
  assign w_stall  = md_busy && in_valid && md_op != 3'd0;
  assign in_ready = !w_stall;
  assign w_load   = !isCacheStall && !isFlush && !w_stall;
  assign w_issue  = in_valid && md_op >= 3'd1 && md_op <= 3'd4 && w_load;
  assign w_sgn    = md_op == 3'd1 || md_op == 3'd3;
  assign w_is_div = md_op == 3'd3 || md_op == 3'd4;
  assign w_dz     = w_is_div && opb == '0;
  assign w_ma     = (w_sgn && opa[DATA_W-1]) ? -opa : opa;
  assign w_mb     = (w_sgn && opb[DATA_W-1]) ? -opb : opb;
  assign w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_sum, r_acc[DATA_W-1:1]};
  assign w_cand     = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_ge       = w_cand >= {1'b0, r_b};
  assign w_diff     = w_cand[DATA_W-1:0] - r_b;
  assign w_div_next = {w_ge ? w_diff : w_cand[DATA_W-1:0], r_acc[DATA_W-2:0], w_ge};
  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_q      = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
  assign w_r      = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
  assign w_fix_hi = r_dz ? r_a : r_div ? w_r : w_prod[2*DATA_W-1:DATA_W];
  assign w_fix_lo = r_dz ? '1 : r_div ? w_q : w_prod[DATA_W-1:0];
  // MDU sequencer: operands latched on issue, one shift-add/restoring step per RUN cycle, sign fix-up in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_issue) begin
        r_a     <= opa;
        r_b     <= w_mb;
        r_div   <= w_is_div;
        r_neg_q <= w_sgn && (opa[DATA_W-1] ^ opb[DATA_W-1]);
        r_neg_r <= w_sgn && opa[DATA_W-1];
        r_dz    <= w_dz;
        r_cnt   <= CW'(DATA_W - 1);
`ifdef MDU_FAST_MUL_EN
        r_acc   <= w_is_div ? {{DATA_W{1'b0}}, w_ma} : {{DATA_W{1'b0}}, w_ma} * {{DATA_W{1'b0}}, w_mb};
        r_state <= (w_dz || !w_is_div) ? S_FIX : S_RUN;
`else
        r_acc   <= {{DATA_W{1'b0}}, w_ma};
        r_state <= w_dz ? S_FIX : S_RUN;
`endif
      end
    end else if (r_state == S_RUN) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) r_state <= S_FIX;
    end else begin
      r_state <= S_IDLE;
    end
  end
  // HI/LO: MDU result in FIX, otherwise MTHI/MTLO under the EX/MEM load conditions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if (w_load && in_valid && md_op == 3'd7) begin
      if (write_reg[0]) r_lo <= opa;
      else r_hi <= opa;
    end
  end
  assign hi = r_hi;
  assign lo = r_lo;
  // EX/MEM register: hold on cache stall, clear on flush, bubble on MDU stall
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_result    <= '0;
      reg_write_reg <= '0;
      reg_valid     <= 1'b0;
    end else if (isCacheStall) begin
      reg_valid <= reg_valid;
    end else if (isFlush) begin
      reg_result    <= '0;
      reg_write_reg <= '0;
      reg_valid     <= 1'b0;
    end else if (w_stall) begin
      reg_valid <= 1'b0;
    end else begin
      reg_result    <= md_op == 3'd5 ? r_hi : md_op == 3'd6 ? r_lo : alu_out;
      reg_write_reg <= write_reg;
      reg_valid     <= in_valid;
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed vectors for ex_stage_md (DATA_W=32, FWD_SRCS=2, iterative multiply)
module tb_ex_stage_md;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, isFlush = 1'b0, isCacheStall = 1'b0;
  logic [2:0] md_op = '0;
  logic [W-1:0] reg1_data = '0, reg2_data = '0, alu_out = '0, opa, opb, reg_result, hi, lo;
  logic [2*W-1:0] fwd_data = '0;
  logic [1:0] fwd_a = '0, fwd_b = '0;
  logic [4:0] write_reg = '0, reg_write_reg;
  logic reg_valid, md_busy;
  int errors = 0, checks = 0;

  ex_stage_md dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .isFlush(isFlush), .isCacheStall(isCacheStall), .md_op(md_op),
    .reg1_data(reg1_data), .reg2_data(reg2_data), .fwd_data(fwd_data),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .alu_out(alu_out), .opa(opa), .opb(opb),
    .write_reg(write_reg), .reg_result(reg_result), .reg_write_reg(reg_write_reg),
    .reg_valid(reg_valid), .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    reg1_data = a;
    reg2_data = b;
    md_op = op;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    md_op = 3'd0;
  endtask

  initial begin
    step(2);
    chk("rst_result", reg_result, 0);
    chk("rst_valid", reg_valid, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", md_busy, 0);
    rst = 1'b0;

    reg1_data = 32'd1;
    reg2_data = 32'd9;
    fwd_data = {32'h55, 32'h33};
    fwd_a = 2'd2;
    #1 chk("fwd_a2", opa, 32'h55);
    fwd_a = 2'd1;
    #1 chk("fwd_a1", opa, 32'h33);
    fwd_a = 2'd3;
    #1 chk("fwd_a3", opa, 32'h1);
    fwd_b = 2'd0;
    #1 chk("fwd_b0", opb, 32'h9);
    fwd_b = 2'd2;
    #1 chk("fwd_b2", opb, 32'h55);
    fwd_a = 2'd0;
    fwd_b = 2'd0;

    in_valid = 1'b1;
    alu_out = 32'h1234;
    write_reg = 5'd7;
    step();
    chk("alu_result", reg_result, 32'h1234);
    chk("alu_dst", reg_write_reg, 7);
    chk("alu_valid", reg_valid, 1);
    alu_out = 32'hBEEF;
    isCacheStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cstall_hold", reg_result, 32'h1234);
    end
    isCacheStall = 1'b0;
    isFlush = 1'b1;
    step();
    chk("flush_valid", reg_valid, 0);
    chk("flush_result", reg_result, 0);
    isFlush = 1'b0;
    in_valid = 1'b0;
    alu_out = 32'h0;
    step();

    issue(3'd1, -32'sd3, 32'd7);
    chk("mult_busy", md_busy, 1);
    md_op = 3'd5;
    in_valid = 1'b1;
    alu_out = 32'hAAAA;
    #1 chk("mfhi_stall", in_ready, 0);
    step(W);
    chk("mult_busy_end", md_busy, 1);
    chk("mfhi_bubble", reg_valid, 0);
    step();
    chk("mult_done", md_busy, 0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    step();
    chk("mfhi_result", reg_result, 32'hFFFFFFFF);
    chk("mfhi_valid", reg_valid, 1);
    md_op = 3'd6;
    step();
    chk("mflo_result", reg_result, 32'hFFFFFFEB);
    in_valid = 1'b0;
    md_op = 3'd0;

    issue(3'd3, -32'sd7, 32'd2);
    step(W + 1);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd4, 32'd7, 32'd0);
    chk("dz_busy", md_busy, 1);
    step();
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 32'd7);
    chk("dz_idle", md_busy, 0);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    step(W + 1);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    step(W + 1);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    write_reg = 5'd0;
    issue(3'd7, 32'h1111, 32'h0);
    write_reg = 5'd1;
    issue(3'd7, 32'h2222, 32'h0);
    chk("mthi", hi, 32'h1111);
    chk("mtlo", lo, 32'h2222);

    isFlush = 1'b1;
    issue(3'd1, 32'd5, 32'd6);
    isFlush = 1'b0;
    chk("flush_issue_busy", md_busy, 0);
    step(W + 1);
    chk("flush_issue_hi", hi, 32'h1111);
    chk("flush_issue_lo", lo, 32'h2222);

    issue(3'd2, 32'd5, 32'd6);
    isFlush = 1'b1;
    isCacheStall = 1'b1;
    step(3);
    chk("run_flush_busy", md_busy, 1);
    isFlush = 1'b0;
    isCacheStall = 1'b0;
    step(W - 2);
    chk("run_flush_hi", hi, 32'h0);
    chk("run_flush_lo", lo, 32'd30);

    issue(3'd1, 32'd5, 32'd6);
    step(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", md_busy, 0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
